immediate_encoder: RTL
======================

IMMEDIATE_ENCODER -- requirements
Module: immediate_encoder

Interface
REQ-001 SHALL have parameter: MAX_ROT, 15, highest rotate_imm index searched (0..15).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  in  1  request valid.
REQ-005 SHALL have port: in_ready  out  1  block can accept a request.
REQ-006 SHALL have port: value  in  32  constant to encode, sampled on accept.
REQ-007 SHALL have port: out_valid  out  1  result valid.
REQ-008 SHALL have port: out_ready  in  1  consumer accepts result.
REQ-009 SHALL have port: encodable  out  1  value has a data-processing immediate form.
REQ-010 SHALL have port: shifter_operand  out  12  {rotate_imm[3:0], imm8[7:0]}; value == imm8 rotated right by 2*rotate_imm.
REQ-011 SHALL have port: use_mvn  out  1  result encodes ~value (see Configuration).

Function
REQ-012 SHALL implement FSM IDLE, SEARCH, DONE.
REQ-013 IDLE: in_ready=1; on in_valid&in_ready SHALL capture value, clear rot counter, enter SEARCH.
REQ-014 SEARCH: in_ready=0; each cycle SHALL form cand = captured value rotated left by 2*rot.
REQ-015 SEARCH hit (cand[31:8]==0): SHALL register encodable=1, shifter_operand={rot,cand[7:0]}, enter DONE.
REQ-016 SEARCH miss with rot<MAX_ROT: SHALL increment rot, stay in SEARCH.
REQ-017 SEARCH miss with rot==MAX_ROT: SHALL register encodable=0, shifter_operand=0, enter DONE (rot counter does not wrap past MAX_ROT).
REQ-018 Search order ascending; smallest matching rotate_imm SHALL be reported; value 0 hits at rot 0.
REQ-019 Latency: hit at rot r SHALL assert out_valid r+2 cycles after accept edge; full miss SHALL take MAX_ROT+3.
REQ-020 DONE: out_valid=1; encodable, shifter_operand, use_mvn SHALL stay stable until out_valid&out_ready.
REQ-021 On out_valid&out_ready SHALL return to IDLE; no same-cycle accept of a new request.
REQ-022 in_valid during SEARCH/DONE SHALL be ignored; value changes after accept SHALL not affect the result.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, rot=0, out_valid=0, encodable=0, shifter_operand=0, use_mvn=0.
REQ-024 in_ready SHALL read 1 in IDLE, including during reset.
REQ-025 Reset mid-SEARCH/DONE SHALL discard the request; no out_valid emitted for it.

Configuration
REQ-026 With IMM_ENC_MVN_EN defined: after a full direct miss, SHALL restart rot=0 on ~value; hit sets use_mvn=1, encodable=1; second miss sets encodable=0, use_mvn=0; worst-case latency 2*(MAX_ROT+1)+2.
REQ-027 Without IMM_ENC_MVN_EN: use_mvn SHALL be tied 0; only the direct search runs.

Verification
REQ-028 value=0x000000FF, out_ready=1 -> out_valid 2 cycles after accept, encodable=1, shifter_operand=0x0FF.
REQ-029 value=0xFF000000 -> encodable=1, shifter_operand=0x4FF, out_valid 6 cycles after accept.
REQ-030 value=0xF000000F -> encodable=1, shifter_operand=0x2FF; value=0x00000102 -> encodable=0, shifter_operand=0x000, out_valid 18 cycles after accept.
REQ-031 value=0x000000FF, out_ready held low 5 cycles -> out_valid and outputs stable, in_ready=0 throughout; IDLE one cycle after handshake.
REQ-032 rst_n pulsed low during SEARCH of 0x00000102 -> outputs zero immediately, in_ready=1, no out_valid; next request 0x0 -> 0x000 encodable=1.
REQ-033 IMM_ENC_MVN_EN defined, value=0xFFFFFF00 -> encodable=1, use_mvn=1, shifter_operand=0x0FF, out_valid 19 cycles after accept.

Source files
------------

// File: rtl/immediate_encoder_if.sv
// Request/result interface for immediate_encoder.
// master: requester side (drives request and out_ready); slave: the encoder.
interface immediate_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value;
    logic        out_valid;
    logic        out_ready;
    logic        encodable;
    logic [11:0] shifter_operand;
    logic        use_mvn;

    modport master (
        output in_valid,
        output value,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  encodable,
        input  shifter_operand,
        input  use_mvn
    );

    modport slave (
        input  in_valid,
        input  value,
        input  out_ready,
        output in_ready,
        output out_valid,
        output encodable,
        output shifter_operand,
        output use_mvn
    );
endinterface

// File: rtl/immediate_encoder.sv
// immediate_encoder: iterative search for a data-processing immediate form
// (imm8 rotated right by 2*rotate_imm) of a 32-bit constant.
// Optional feature macro: IMM_ENC_MVN_EN -- after a full direct miss, retry the
// search on ~value and flag a hit with use_mvn.
module immediate_encoder #(
    parameter int unsigned MAX_ROT = 15
) (
    input logic               clk,
    input logic               rst_n,
    immediate_encoder_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StSearch, StDone} state_t;

    localparam logic [3:0] MaxRot = MAX_ROT[3:0];

    state_t      state_q, state_d;
    logic [3:0]  rot_q, rot_d;
    logic [31:0] val_q, val_d;
    // eval_q low marks the load cycle of a pass, in which no candidate is checked.
    logic        eval_q, eval_d;
    // pass_q set once the direct pass has been exhausted.
    logic        pass_q, pass_d;
    logic        enc_q, enc_d;
    logic [11:0] sop_q, sop_d;
`ifdef IMM_ENC_MVN_EN
    logic        mvn_q, mvn_d;
`endif

    logic [31:0] operand;
    logic [4:0]  lsh;
    logic [5:0]  rsh;
    logic [31:0] cand;

    // Candidate: operand rotated left by 2*rot (a shift by 32 yields zero).
    always_comb begin
`ifdef IMM_ENC_MVN_EN
        operand = pass_q ? ~val_q : val_q;
`else
        operand = val_q;
`endif
        lsh  = {rot_q, 1'b0};
        rsh  = 6'd32 - {1'b0, lsh};
        cand = (operand << lsh) | (operand >> rsh);
    end

    // Next-state and result logic.
    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        val_d   = val_q;
        eval_d  = eval_q;
        pass_d  = pass_q;
        enc_d   = enc_q;
        sop_d   = sop_q;
`ifdef IMM_ENC_MVN_EN
        mvn_d   = mvn_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    val_d   = bus.value;
                    rot_d   = 4'd0;
                    eval_d  = 1'b0;
                    pass_d  = 1'b0;
                    enc_d   = 1'b0;
                    sop_d   = 12'h000;
`ifdef IMM_ENC_MVN_EN
                    mvn_d   = 1'b0;
`endif
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (!eval_q) begin
`ifdef IMM_ENC_MVN_EN
                    eval_d = 1'b1;
`else
                    if (pass_q) begin
                        enc_d   = 1'b0;
                        sop_d   = 12'h000;
                        state_d = StDone;
                    end else begin
                        eval_d = 1'b1;
                    end
`endif
                end else if (cand[31:8] == 24'h0) begin
                    enc_d   = 1'b1;
                    sop_d   = {rot_q, cand[7:0]};
`ifdef IMM_ENC_MVN_EN
                    mvn_d   = pass_q;
`endif
                    state_d = StDone;
                end else if (rot_q < MaxRot) begin
                    rot_d = rot_q + 4'd1;
                end else begin
`ifdef IMM_ENC_MVN_EN
                    if (!pass_q) begin
                        pass_d = 1'b1;
                        rot_d  = 4'd0;
                        eval_d = 1'b0;
                    end else begin
                        enc_d   = 1'b0;
                        sop_d   = 12'h000;
                        mvn_d   = 1'b0;
                        state_d = StDone;
                    end
`else
                    pass_d = 1'b1;
                    eval_d = 1'b0;
`endif
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rot_q   <= 4'd0;
            val_q   <= 32'h0;
            eval_q  <= 1'b0;
            pass_q  <= 1'b0;
            enc_q   <= 1'b0;
            sop_q   <= 12'h000;
`ifdef IMM_ENC_MVN_EN
            mvn_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            val_q   <= val_d;
            eval_q  <= eval_d;
            pass_q  <= pass_d;
            enc_q   <= enc_d;
            sop_q   <= sop_d;
`ifdef IMM_ENC_MVN_EN
            mvn_q   <= mvn_d;
`endif
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        bus.in_ready        = (state_q == StIdle);
        bus.out_valid       = (state_q == StDone);
        bus.encodable       = enc_q;
        bus.shifter_operand = sop_q;
`ifdef IMM_ENC_MVN_EN
        bus.use_mvn         = mvn_q;
`else
        bus.use_mvn         = 1'b0;
`endif
    end

endmodule
